// File: rtl/tl_pkg.sv
// Shared types and lamp encodings for the parametrised intersection controller.
package tl_pkg;

    typedef enum logic [2:0] {
        AR_PRE,
        NS_G,
        NS_Y,
        AR_MID,
        EW_G,
        EW_Y,
        FLASH
    } tl_state_e;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamp_pair_t;

    // flash_phase 0 is the lit half of the night-mode blink.
    function automatic lamp_pair_t state_lamps(tl_state_e s, logic flash_phase);
        lamp_pair_t l;
        l.ns = RED;
        l.ew = RED;
        case (s)
            NS_G:    l.ns = GRN;
            NS_Y:    l.ns = YEL;
            EW_G:    l.ew = GRN;
            EW_Y:    l.ew = YEL;
            FLASH: begin
                l.ns = flash_phase ? OFF : YEL;
                l.ew = flash_phase ? OFF : RED;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clocks (every cycle when TICK_DIV=1).
module tl_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)                count <= '0;
        else if (count == LAST) count <= '0;
        else                    count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/traffic_light_ctrl_param.sv
// Four-way intersection controller: timed phases, all-red clearance, E/W demand
// actuation, night flashing and a seconds-remaining countdown.
module traffic_light_ctrl_param
    import tl_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int CNT_W      = 8,
    parameter int GREEN_NS_S = 30,
    parameter int GREEN_EW_S = 20,
    parameter int YELLOW_S   = 3,
    parameter int ALLRED_S   = 2,
    parameter int DEMAND_EN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ew_req,
    input  logic             night_mode,
    output logic [2:0]       light_N,
    output logic [2:0]       light_S,
    output logic [2:0]       light_E,
    output logic [2:0]       light_W,
    output logic [CNT_W-1:0] remaining,
    output logic             flashing
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (TICK_DIV < 1 ||
        GREEN_NS_S < 1 || GREEN_NS_S > CNT_MAX ||
        GREEN_EW_S < 1 || GREEN_EW_S > CNT_MAX ||
        YELLOW_S   < 1 || YELLOW_S   > CNT_MAX ||
        ALLRED_S   < 1 || ALLRED_S   > CNT_MAX) begin : g_param_check
        $error("traffic_light_ctrl_param: TICK_DIV or a duration is outside its legal range");
    end

    localparam logic [CNT_W-1:0] D_GNS = CNT_W'(GREEN_NS_S);
    localparam logic [CNT_W-1:0] D_GEW = CNT_W'(GREEN_EW_S);
    localparam logic [CNT_W-1:0] D_YEL = CNT_W'(YELLOW_S);
    localparam logic [CNT_W-1:0] D_AR  = CNT_W'(ALLRED_S);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic             tick;
    tl_state_e        state, state_n;
    logic [CNT_W-1:0] rem_q, rem_n;
    logic             req_latch, req_n;
    logic             flash_phase, phase_n;
    lamp_pair_t       lamps_q, lamps_n;
    logic             flash_q, flash_n;
    logic             req_eff;

    tl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A request in the same cycle as the expiry tick counts as already latched.
    assign req_eff = req_latch | ew_req;

    // NOTE: every combinational output gets a default first; a missing path would otherwise infer a latch.
    always_comb begin
        state_n = state;
        rem_n   = rem_q;
        req_n   = req_latch;
        phase_n = flash_phase;

        if (tick) begin
            if (state != FLASH && rem_q > ONE) begin
                rem_n = rem_q - ONE;
            end else begin
                case (state)
                    AR_PRE, AR_MID: begin
                        if (night_mode) begin
                            state_n = FLASH;
                            rem_n   = '0;
                            phase_n = 1'b0;
                        end else if (state == AR_PRE) begin
                            state_n = NS_G;
                            rem_n   = D_GNS;
                        end else begin
                            state_n = EW_G;
                            rem_n   = D_GEW;
                        end
                    end
                    NS_G: begin
                        // Without demand the green holds at zero until a request shows up.
                        if (DEMAND_EN == 0 || req_eff) begin
                            state_n = NS_Y;
                            rem_n   = D_YEL;
                        end else begin
                            rem_n   = '0;
                        end
                    end
                    NS_Y: begin
                        state_n = AR_MID;
                        rem_n   = D_AR;
                    end
                    EW_G: begin
                        state_n = EW_Y;
                        rem_n   = D_YEL;
                    end
                    EW_Y: begin
                        state_n = AR_PRE;
                        rem_n   = D_AR;
                    end
                    FLASH: begin
                        if (!night_mode) begin
                            state_n = AR_PRE;
                            rem_n   = D_AR;
                        end else begin
                            phase_n = ~flash_phase;
                        end
                    end
                    default: begin
                        state_n = AR_PRE;
                        rem_n   = D_AR;
                    end
                endcase
            end
        end

        // Entering EW_G serves the request; requests during EW_G are ignored.
        if (state_n == EW_G && state != EW_G) req_n = 1'b0;
        else if (ew_req && state != EW_G)     req_n = 1'b1;

        lamps_n = state_lamps(state_n, phase_n);
        flash_n = (state_n == FLASH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= AR_PRE;
            rem_q       <= D_AR;
            req_latch   <= 1'b0;
            flash_phase <= 1'b0;
            lamps_q     <= '{ns: RED, ew: RED};
            flash_q     <= 1'b0;
        end else begin
            state       <= state_n;
            rem_q       <= rem_n;
            req_latch   <= req_n;
            flash_phase <= phase_n;
            lamps_q     <= lamps_n;
            flash_q     <= flash_n;
        end
    end

    assign light_N   = lamps_q.ns;
    assign light_S   = lamps_q.ns;
    assign light_E   = lamps_q.ew;
    assign light_W   = lamps_q.ew;
    assign remaining = rem_q;
    assign flashing  = flash_q;

endmodule
